axi_sram_ctrl: RTL and testbench

AXI4 slave controller that sequences accesses from the core's flat AXI memory master port onto a single-port on-chip SRAM, such as the IMEM/DMEM banks.
- Serialises reads and writes one burst at a time.
- Arbitrates AW against AR round-robin.
- Translates INCR/FIXED bursts into per-beat SRAM accesses.
- Answers illegal requests with SLVERR and never touches the SRAM for them.

---
 rtl/axi_sram_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_sram_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_ctrl.sv
`default_nettype none
// axi_sram_ctrl: AXI4 slave that serialises one burst at a time onto a single-port 64-bit SRAM.
// Revision: 1.0
module axi_sram_ctrl #(
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter logic [63:0] MEM_BASE     = 64'h0004_0000,
  parameter logic [63:0] MEM_LENGTH   = 64'h0000_4000,
  parameter int unsigned SRAM_AW      = 11
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AXI_ID_WIDTH-1:0] io_axi_mem_awid,
  input  logic [63:0]             io_axi_mem_awaddr,
  input  logic [7:0]              io_axi_mem_awlen,
  input  logic [2:0]              io_axi_mem_awsize,
  input  logic [1:0]              io_axi_mem_awburst,
  input  logic [5:0]              io_axi_mem_awatop,
  input  logic                    io_axi_mem_awvalid,
  output logic                    io_axi_mem_awready,
  input  logic [63:0]             io_axi_mem_wdata,
  input  logic [7:0]              io_axi_mem_wstrb,
  input  logic                    io_axi_mem_wlast,
  input  logic                    io_axi_mem_wvalid,
  output logic                    io_axi_mem_wready,
  output logic [AXI_ID_WIDTH-1:0] io_axi_mem_bid,
  output logic [1:0]              io_axi_mem_bresp,
  output logic                    io_axi_mem_bvalid,
  input  logic                    io_axi_mem_bready,
  input  logic [AXI_ID_WIDTH-1:0] io_axi_mem_arid,
  input  logic [63:0]             io_axi_mem_araddr,
  input  logic [7:0]              io_axi_mem_arlen,
  input  logic [2:0]              io_axi_mem_arsize,
  input  logic [1:0]              io_axi_mem_arburst,
  input  logic                    io_axi_mem_arvalid,
  output logic                    io_axi_mem_arready,
  output logic [AXI_ID_WIDTH-1:0] io_axi_mem_rid,
  output logic [63:0]             io_axi_mem_rdata,
  output logic [1:0]              io_axi_mem_rresp,
  output logic                    io_axi_mem_rlast,
  output logic                    io_axi_mem_rvalid,
  input  logic                    io_axi_mem_rready,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [SRAM_AW-1:0]      sram_addr_o,
  output logic [63:0]             sram_wdata_o,
  output logic [7:0]              sram_be_o,
  input  logic [63:0]             sram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  state_e                  state, state_next;
  logic                    last_grant_wr;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [63:0]             addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic                    fixed_q;
  logic                    err_q;
  logic [8:0]              beat_q;
  logic [1:0]              bresp_q;
  logic [63:0]             rdata_q;

  logic                    grant_wr, grant_rd;
  logic                    aw_err, ar_err;
  logic                    w_hs, r_hs, wr_en, rd_en, last_beat;
  logic [63:0]             addr_next;
  logic [SRAM_AW-1:0]      word_addr;

  // Bursts whose span leaves the window are checked in 65 bits so a top-of-space address cannot wrap.
  function automatic logic req_err(input logic [63:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [64:0] nbytes;
    logic [64:0] top;
    nbytes = (burst == BURST_FIXED) ? (65'd1 << size) : ((65'd1 + {57'd0, len}) << size);
    top    = {1'b0, addr} + nbytes;
    return size[2] || burst[1] || (addr < MEM_BASE) ||
           (top > ({1'b0, MEM_BASE} + {1'b0, MEM_LENGTH}));
  endfunction

  assign aw_err    = req_err(io_axi_mem_awaddr, io_axi_mem_awlen, io_axi_mem_awsize,
                             io_axi_mem_awburst) || (io_axi_mem_awatop != 6'd0);
  assign ar_err    = req_err(io_axi_mem_araddr, io_axi_mem_arlen, io_axi_mem_arsize,
                             io_axi_mem_arburst);
  assign addr_next = fixed_q ? addr_q : addr_q + (64'd1 << size_q);
  assign word_addr = addr_q[SRAM_AW+2:3] - MEM_BASE[SRAM_AW+2:3];
  assign last_beat = (beat_q == {1'b0, len_q});
  assign w_hs      = (state == WR_DATA) && io_axi_mem_wvalid;
  assign r_hs      = (state == RD_DATA) && io_axi_mem_rready;
  // Beats beyond len+1 are absorbed without touching the SRAM.
  assign wr_en     = w_hs && !err_q && (beat_q <= {1'b0, len_q});
  assign rd_en     = (state == RD_REQ) && !err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    grant_wr           = 1'b0;
    grant_rd           = 1'b0;
    io_axi_mem_awready = 1'b0;
    io_axi_mem_arready = 1'b0;
    io_axi_mem_wready  = 1'b0;
    io_axi_mem_bvalid  = 1'b0;
    io_axi_mem_rvalid  = 1'b0;
    io_axi_mem_rlast   = 1'b0;
    io_axi_mem_rresp   = RESP_OKAY;
    unique case (state)
      IDLE: begin
        if (rst_ni) begin
          if (io_axi_mem_awvalid && io_axi_mem_arvalid) begin
            grant_wr = !last_grant_wr;
            grant_rd = last_grant_wr;
          end else begin
            grant_wr = io_axi_mem_awvalid;
            grant_rd = io_axi_mem_arvalid;
          end
        end
        io_axi_mem_awready = grant_wr;
        io_axi_mem_arready = grant_rd;
        if (grant_wr) begin
          state_next = WR_DATA;
        end else if (grant_rd) begin
          state_next = ar_err ? RD_DATA : RD_REQ;
        end
      end
      WR_DATA: begin
        io_axi_mem_wready = 1'b1;
        if (w_hs && io_axi_mem_wlast) state_next = WR_RESP;
      end
      WR_RESP: begin
        io_axi_mem_bvalid = 1'b1;
        if (io_axi_mem_bready) state_next = IDLE;
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = RD_DATA;
      RD_DATA: begin
        io_axi_mem_rvalid = 1'b1;
        io_axi_mem_rlast  = last_beat;
        io_axi_mem_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (r_hs) begin
          if (last_beat)  state_next = IDLE;
          else if (err_q) state_next = RD_DATA;
          else            state_next = RD_REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_wr <= 1'b1;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      fixed_q       <= 1'b0;
      err_q         <= 1'b0;
      beat_q        <= '0;
      bresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
    end else begin
      if (grant_wr || grant_rd) last_grant_wr <= grant_wr;
      if (grant_wr) begin
        id_q    <= io_axi_mem_awid;
        addr_q  <= io_axi_mem_awaddr;
        len_q   <= io_axi_mem_awlen;
        size_q  <= io_axi_mem_awsize;
        fixed_q <= (io_axi_mem_awburst == BURST_FIXED);
        err_q   <= aw_err;
        beat_q  <= '0;
        bresp_q <= RESP_OKAY;
      end else if (grant_rd) begin
        id_q    <= io_axi_mem_arid;
        addr_q  <= io_axi_mem_araddr;
        len_q   <= io_axi_mem_arlen;
        size_q  <= io_axi_mem_arsize;
        fixed_q <= (io_axi_mem_arburst == BURST_FIXED);
        err_q   <= ar_err;
        beat_q  <= '0;
        rdata_q <= '0;
      end
      if (w_hs) begin
        if (beat_q != 9'd256) beat_q <= beat_q + 9'd1;
        addr_q <= addr_next;
        if (io_axi_mem_wlast) begin
          bresp_q <= (err_q || !last_beat) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      if (state == RD_WAIT) rdata_q <= sram_rdata_i;
      if (r_hs && !last_beat) begin
        beat_q <= beat_q + 9'd1;
        addr_q <= addr_next;
      end
    end
  end

  assign io_axi_mem_bid   = id_q;
  assign io_axi_mem_bresp = bresp_q;
  assign io_axi_mem_rid   = id_q;
  assign io_axi_mem_rdata = rdata_q;
  assign sram_req_o       = wr_en || rd_en;
  assign sram_we_o        = wr_en;
  assign sram_addr_o      = sram_req_o ? word_addr : '0;
  assign sram_wdata_o     = wr_en ? io_axi_mem_wdata : '0;
  assign sram_be_o        = wr_en ? io_axi_mem_wstrb : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_ctrl.sv
`default_nettype none
// tb_axi_sram_ctrl: directed self-checking bench for axi_sram_ctrl with a behavioural SRAM.
// Revision: 1.0
module tb_axi_sram_ctrl;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [5:0]  awatop;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        sram_req, sram_we;
  logic [10:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0]  sram_be;
  logic [63:0] sram_rdata = '0;

  always #5 clk = ~clk;

  axi_sram_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .io_axi_mem_awid(awid), .io_axi_mem_awaddr(awaddr), .io_axi_mem_awlen(awlen),
    .io_axi_mem_awsize(awsize), .io_axi_mem_awburst(awburst), .io_axi_mem_awatop(awatop),
    .io_axi_mem_awvalid(awvalid), .io_axi_mem_awready(awready),
    .io_axi_mem_wdata(wdata), .io_axi_mem_wstrb(wstrb), .io_axi_mem_wlast(wlast),
    .io_axi_mem_wvalid(wvalid), .io_axi_mem_wready(wready),
    .io_axi_mem_bid(bid), .io_axi_mem_bresp(bresp), .io_axi_mem_bvalid(bvalid),
    .io_axi_mem_bready(bready),
    .io_axi_mem_arid(arid), .io_axi_mem_araddr(araddr), .io_axi_mem_arlen(arlen),
    .io_axi_mem_arsize(arsize), .io_axi_mem_arburst(arburst),
    .io_axi_mem_arvalid(arvalid), .io_axi_mem_arready(arready),
    .io_axi_mem_rid(rid), .io_axi_mem_rdata(rdata), .io_axi_mem_rresp(rresp),
    .io_axi_mem_rlast(rlast), .io_axi_mem_rvalid(rvalid), .io_axi_mem_rready(rready),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  // Behavioural single-port SRAM: one-cycle read latency, byte-enabled writes.
  logic [63:0] mem [0:2047];
  logic        mem_loaded = 1'b0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [10:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic [7:0]  last_wr_be   = '0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int i = 0; i < 8; i++) if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= sram_addr;
        last_wr_data <= sram_wdata;
        last_wr_be   <= sram_be;
      end else begin
        sram_rdata <= mem[sram_addr];
        rd_cnt     <= rd_cnt + 1;
      end
    end
  end

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_data [0:7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic aw_phase(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [5:0] atop, input string tag);
    int k;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awatop = atop;
    awvalid = 1'b1;
    k = 0; #1;
    while (!awready && k < 20) begin @(negedge clk); k++; #1; end
    check({tag, "_awready"}, awready, 1);
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input string tag);
    int k;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    k = 0; #1;
    while (!arready && k < 20) begin @(negedge clk); k++; #1; end
    check({tag, "_arready"}, arready, 1);
  endtask

  task automatic w_phase(input int nbeats, input logic [63:0] d0, input logic [7:0] strb,
                         input int bdelay, input logic [3:0] exp_id, input logic [1:0] exp_resp,
                         input int exp_writes, input string tag);
    int k;
    int base_wr;
    logic held;
    base_wr = wr_cnt;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      wvalid = 1'b1; wdata = d0 + 64'(b); wstrb = strb; wlast = (b == nbeats - 1);
      k = 0; #1;
      while (!wready && k < 20) begin @(negedge clk); k++; #1; end
      check({tag, "_wready"}, wready, 1);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = (bdelay == 0);
    k = 0; #1;
    while (!bvalid && k < 20) begin @(negedge clk); k++; #1; end
    check({tag, "_bvalid"}, bvalid, 1);
    held = 1'b1;
    for (int i = 0; i < bdelay; i++) begin @(negedge clk); #1; if (!bvalid) held = 1'b0; end
    if (bdelay > 0) check({tag, "_bvalid_held"}, held, 1);
    bready = 1'b1;
    check({tag, "_bid"}, bid, exp_id);
    check({tag, "_bresp"}, bresp, exp_resp);
    @(negedge clk);
    bready = 1'b0; #1;
    check({tag, "_bvalid_drop"}, bvalid, 0);
    check({tag, "_writes"}, wr_cnt - base_wr, exp_writes);
  endtask

  task automatic r_phase(input logic [3:0] id, input logic [7:0] len, input bit err,
                         input int stall_beat, input int stall_cycles, input string tag);
    int gap;
    int base_rd;
    int rd_snap;
    logic [63:0] h_data;
    logic [3:0] h_id;
    logic h_last;
    logic stable;
    base_rd = rd_cnt;
    for (int b = 0; b <= int'(len); b++) begin
      gap = 0;
      do begin
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; rready = (b != stall_beat);
        gap++; #1;
      end while (!rvalid && gap < 50);
      check({tag, "_gap"}, gap, err ? 1 : 3);
      check({tag, "_rdata"}, rdata, err ? 64'd0 : exp_data[b]);
      check({tag, "_rresp"}, rresp, err ? SLVERR : OKAY);
      check({tag, "_rlast"}, rlast, (b == int'(len)));
      check({tag, "_rid"}, rid, id);
      if (b == stall_beat) begin
        h_data = rdata; h_id = rid; h_last = rlast; stable = 1'b1; rd_snap = rd_cnt;
        for (int i = 0; i < stall_cycles; i++) begin
          @(negedge clk); #1;
          if (!rvalid || rdata !== h_data || rid !== h_id || rlast !== h_last) stable = 1'b0;
        end
        check({tag, "_stall_stable"}, stable, 1);
        check({tag, "_stall_noreq"}, rd_cnt - rd_snap, 0);
        rready = 1'b1;
      end
    end
    @(negedge clk);
    rready = 1'b0; #1;
    check({tag, "_rvalid_drop"}, rvalid, 0);
    check({tag, "_reads"}, rd_cnt - base_rd, err ? 0 : int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_ni = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awatop = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awvalid = 1'b1; arvalid = 1'b1;
    #1 rst_ni = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_readies", {awready, arready, wready}, 0);
    check("rst_valids", {bvalid, rvalid, rlast}, 0);
    check("rst_sram_ctl", {sram_req, sram_we}, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_sram_be", sram_be, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp_ids", {bresp, rresp, bid, rid}, 0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); rst_ni = 1'b1;

    aw_phase(4'h5, 64'h4_0008, 8'd0, INCR, 6'd0, "t1");
    w_phase(1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 4'h5, OKAY, 1, "t1");
    check("t1_sram_addr", last_wr_addr, 11'd1);
    check("t1_sram_wdata", last_wr_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1_sram_be", last_wr_be, 8'hFF);

    exp_data[0] = pat(0); exp_data[1] = 64'hDEAD_BEEF_CAFE_F00D;
    exp_data[2] = pat(2); exp_data[3] = pat(3);
    ar_phase(4'h3, 64'h4_0000, 8'd3, INCR, "t2");
    r_phase(4'h3, 8'd3, 1'b0, -1, 0, "t2");

    for (int i = 0; i < 3; i++) exp_data[i] = pat(2);
    ar_phase(4'h6, 64'h4_0010, 8'd2, FIXED, "fixed");
    r_phase(4'h6, 8'd2, 1'b0, -1, 0, "fixed");

    ar_phase(4'h7, 64'h4_3FF8, 8'd1, INCR, "t4_rd");
    r_phase(4'h7, 8'd1, 1'b1, -1, 0, "t4_rd");
    aw_phase(4'h8, 64'h3_FFF8, 8'd1, INCR, 6'd0, "t4_wr");
    w_phase(2, 64'h1111, 8'hFF, 0, 4'h8, SLVERR, 0, "t4_wr");

    aw_phase(4'h2, 64'h4_3FF8, 8'd0, INCR, 6'd0, "edge_wr");
    w_phase(1, 64'h1122_3344_5566_7788, 8'h0F, 0, 4'h2, OKAY, 1, "edge_wr");
    check("edge_sram_addr", last_wr_addr, 11'd2047);
    exp_data[0] = 64'hA5A5_0000_5566_7788;
    ar_phase(4'h2, 64'h4_3FF8, 8'd0, INCR, "edge_rd");
    r_phase(4'h2, 8'd0, 1'b0, -1, 0, "edge_rd");

    exp_data[0] = pat(4); exp_data[1] = pat(5); exp_data[2] = pat(6);
    ar_phase(4'hC, 64'h4_0020, 8'd2, INCR, "t5_rd");
    r_phase(4'hC, 8'd2, 1'b0, 1, 5, "t5_rd");
    aw_phase(4'hD, 64'h4_0030, 8'd0, INCR, 6'd0, "t5_wr");
    w_phase(1, 64'h5555, 8'hFF, 4, 4'hD, OKAY, 1, "t5_wr");

    aw_phase(4'h1, 64'h4_0040, 8'd0, INCR, 6'h20, "atop");
    w_phase(1, 64'h6666, 8'hFF, 0, 4'h1, SLVERR, 0, "atop");
    aw_phase(4'h4, 64'h4_0040, 8'd3, WRAP, 6'd0, "wrap");
    w_phase(4, 64'h7777, 8'hFF, 0, 4'h4, SLVERR, 0, "wrap");
    aw_phase(4'hE, 64'h4_0100, 8'd3, INCR, 6'd0, "short");
    w_phase(2, 64'h8888, 8'hFF, 0, 4'hE, SLVERR, 2, "short");

    aw_phase(4'h9, 64'h4_0300, 8'd3, INCR, 6'd0, "rst_mid");
    base = wr_cnt;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 64'h1; wstrb = 8'hFF; wlast = 1'b0;
    @(negedge clk);
    wdata = 64'h2;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_wready", wready, 0);
    check("rst_mid_sram", {sram_req, sram_we}, 0);
    check("rst_mid_wdata", sram_wdata, 0);
    check("rst_mid_bvalid", bvalid, 0);
    check("rst_mid_partial", wr_cnt - base, 1);
    wvalid = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    aw_phase(4'h9, 64'h4_0300, 8'd0, INCR, 6'd0, "post_rst");
    w_phase(1, 64'h0BAD_F00D_1234_5678, 8'hFF, 0, 4'h9, OKAY, 1, "post_rst");
    exp_data[0] = 64'h0BAD_F00D_1234_5678;
    ar_phase(4'h9, 64'h4_0300, 8'd0, INCR, "post_rst_rd");
    r_phase(4'h9, 8'd0, 1'b0, -1, 0, "post_rst_rd");

    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    exp_data[0] = pat(0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      awid = 4'hA; awaddr = 64'h4_0200; awlen = 8'd0; awsize = 3'd3; awburst = INCR;
      awatop = 6'd0; awvalid = 1'b1;
      arid = 4'hB; araddr = 64'h4_0000; arlen = 8'd0; arsize = 3'd3; arburst = INCR;
      arvalid = 1'b1;
      #1;
      check("tie_arready", arready, (t % 2 == 0));
      check("tie_awready", awready, (t % 2 == 1));
      if (arready) r_phase(4'hB, 8'd0, 1'b0, -1, 0, "tie_rd");
      else w_phase(1, 64'h7700 + 64'(t), 8'hFF, 0, 4'hA, OKAY, 1, "tie_wr");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
